// File: rtl/simon_sequencer.sv
// Simon sequence memory: appends LFSR colours, replays them with fixed on/off timing, then
// checks player entries. Optional SIMON_SPEEDUP_EN shortens the ON time for long sequences.
module simon_sequencer #(
    parameter int unsigned MAX_LEN   = 32,
    parameter int unsigned ON_TICKS  = 25_000_000,
    parameter int unsigned OFF_TICKS = 12_500_000,
    localparam int unsigned LenW     = $clog2(MAX_LEN + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      random_bits,
    input  logic            append,
    input  logic            clear,
    input  logic            play,
    input  logic            check_valid,
    input  logic [1:0]      check_color,
    output logic [1:0]      color,
    output logic            enable,
    output logic            busy,
    output logic            entering,
    output logic            done,
    output logic            match,
    output logic            mismatch,
    output logic            complete,
    output logic [LenW-1:0] length,
    output logic            full
);

    localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LenW-1:0] MaxLen = LenW'(MAX_LEN);
    localparam logic [LenW-1:0] One    = LenW'(1);

    typedef enum logic [1:0] {StIdle, StOn, StOff, StEntry} state_e;

    state_e          state_q, state_d;
    logic [1:0]      mem [MAX_LEN];
    logic [LenW-1:0] len_q, len_d, idx_q, idx_d, chk_q, chk_d;
    logic [31:0]     tick_q, tick_d, on_len_q, on_len_d, on_sel;
    logic [1:0]      color_q, color_d;
    logic            full_q, wr_en;
    logic            done_d, match_d, mismatch_d, complete_d;
    logic            enable_q, busy_q, entering_q, done_q, match_q, mismatch_q, complete_q;

`ifdef SIMON_SPEEDUP_EN
    always_comb begin
        if (32'(len_q) >= 32'd16)     on_sel = ON_TICKS >> 2;
        else if (32'(len_q) >= 32'd8) on_sel = ON_TICKS >> 1;
        else                          on_sel = ON_TICKS;
    end
`else
    assign on_sel = ON_TICKS;
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        chk_d      = chk_q;
        tick_d     = tick_q;
        on_len_d   = on_len_q;
        wr_en      = 1'b0;
        done_d     = 1'b0;
        match_d    = 1'b0;
        mismatch_d = 1'b0;
        complete_d = 1'b0;
        if (clear) begin
            state_d = StIdle;
            len_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (append && !full_q) begin
                        wr_en = 1'b1;
                        len_d = len_q + One;
                    end else if (play) begin
                        if (len_q == '0) begin
                            done_d = 1'b1;
                        end else begin
                            idx_d    = '0;
                            tick_d   = '0;
                            on_len_d = on_sel;
                            state_d  = StOn;
                        end
                    end
                end
                StOn: begin
                    if (tick_q == on_len_q - 32'd1) begin
                        tick_d  = '0;
                        state_d = StOff;
                    end else begin
                        tick_d = tick_q + 32'd1;
                    end
                end
                StOff: begin
                    if (tick_q == OFF_TICKS - 32'd1) begin
                        tick_d = '0;
                        if (idx_q == len_q - One) begin
                            done_d  = 1'b1;
                            chk_d   = '0;
                            state_d = StEntry;
                        end else begin
                            idx_d   = idx_q + One;
                            state_d = StOn;
                        end
                    end else begin
                        tick_d = tick_q + 32'd1;
                    end
                end
                StEntry: begin
                    if (check_valid) begin
                        if (check_color == mem[chk_q[IdxW-1:0]]) begin
                            match_d = 1'b1;
                            chk_d   = chk_q + One;
                            if (chk_q == len_q - One) begin
                                complete_d = 1'b1;
                                state_d    = StIdle;
                            end
                        end else begin
                            mismatch_d = 1'b1;
                            state_d    = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        // Colour is loaded from the next index so it is valid on the first lit cycle.
        color_d = (state_d == StOn) ? mem[idx_d[IdxW-1:0]] : color_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[len_q[IdxW-1:0]] <= random_bits;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            len_q      <= '0;
            idx_q      <= '0;
            chk_q      <= '0;
            tick_q     <= '0;
            on_len_q   <= ON_TICKS;
            color_q    <= '0;
            full_q     <= 1'b0;
            enable_q   <= 1'b0;
            busy_q     <= 1'b0;
            entering_q <= 1'b0;
            done_q     <= 1'b0;
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            chk_q      <= chk_d;
            tick_q     <= tick_d;
            on_len_q   <= on_len_d;
            color_q    <= color_d;
            full_q     <= (len_d == MaxLen);
            enable_q   <= (state_d == StOn);
            busy_q     <= (state_d == StOn) || (state_d == StOff);
            entering_q <= (state_d == StEntry);
            done_q     <= done_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
            complete_q <= complete_d;
        end
    end

    assign color    = color_q;
    assign enable   = enable_q;
    assign busy     = busy_q;
    assign entering = entering_q;
    assign done     = done_q;
    assign match    = match_q;
    assign mismatch = mismatch_q;
    assign complete = complete_q;
    assign length   = len_q;
    assign full     = full_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Scoreboard bench for simon_sequencer: stimulus pushes expected per-cycle activity records,
// a negedge monitor pops and compares whenever the DUT is busy or pulses a result.
module tb_simon_sequencer;

    localparam int unsigned MaxLen = 4;
    localparam int unsigned OnT    = 3;
    localparam int unsigned OffT   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] random_bits = '0;
    logic       append = 1'b0, clear = 1'b0, play = 1'b0, check_valid = 1'b0;
    logic [1:0] check_color = '0;
    logic [1:0] color;
    logic       enable, busy, entering, done, match, mismatch, complete, full;
    logic [2:0] length;

    simon_sequencer #(
        .MAX_LEN  (MaxLen),
        .ON_TICKS (OnT),
        .OFF_TICKS(OffT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .random_bits(random_bits),
        .append     (append),
        .clear      (clear),
        .play       (play),
        .check_valid(check_valid),
        .check_color(check_color),
        .color      (color),
        .enable     (enable),
        .busy       (busy),
        .entering   (entering),
        .done       (done),
        .match      (match),
        .mismatch   (mismatch),
        .complete   (complete),
        .length     (length),
        .full       (full)
    );

    always #5 clk = ~clk;

    // Record layout: {busy, enable, color (0 when dark), done, match, mismatch, complete, entering}
    typedef logic [8:0] rec_t;
    rec_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic rec_t mk(logic b, logic en, logic [1:0] c, logic dn, logic m, logic mm,
                                logic cp, logic ent);
        return {b, en, c, dn, m, mm, cp, ent};
    endfunction

    always @(negedge clk) begin
        rec_t obs;
        rec_t want;
        if (busy || done || match || mismatch || complete) begin
            obs = {busy, enable, enable ? color : 2'b00, done, match, mismatch, complete, entering};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_unexpected got %b required no activity at %0t", obs, $time);
            end else begin
                want = exp_q.pop_front();
                if (obs !== want) begin
                    n_err++;
                    $display("FAIL scoreboard_record got %b required %b at %0t", obs, want, $time);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %0h required %0h", name, got, want);
        end
    endtask

    task automatic drain(input string name);
        int b = 0;
        while (exp_q.size() != 0 && b < 200) begin
            tick(1);
            b++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s got %0d pending records required 0", name, exp_q.size());
            exp_q.delete();
        end
        tick(1);
    endtask

    task automatic push_playback(input int n, input logic [7:0] cols);
        for (int i = 0; i < n; i++) begin
            repeat (OnT) exp_q.push_back(mk(1, 1, cols[2*i +: 2], 0, 0, 0, 0, 0));
            repeat (OffT) exp_q.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0, 0));
        end
        exp_q.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 1));
    endtask

    task automatic do_append(input logic [1:0] c);
        random_bits = c;
        append = 1'b1;
        tick(1);
        append = 1'b0;
    endtask

    task automatic do_play();
        play = 1'b1;
        tick(1);
        play = 1'b0;
    endtask

    task automatic do_check(input logic [1:0] c);
        check_color = c;
        check_valid = 1'b1;
        tick(1);
        check_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("reset_outputs", {color, enable, busy, entering, done, match, mismatch, complete,
                              length, full}, '0);
        reset = 1'b1;
        tick(1);

        do_append(2'd2);
        do_append(2'd1);
        chk("length_after_two", length, 2);
        chk("full_after_two", full, 0);
        push_playback(2, 8'b0000_0110);
        do_play();
        drain("playback_2_1");
        chk("entering_after_play", entering, 1);

        exp_q.push_back(mk(0, 0, 2'b00, 0, 1, 0, 0, 1));
        do_check(2'd2);
        exp_q.push_back(mk(0, 0, 2'b00, 0, 1, 0, 1, 0));
        do_check(2'd1);
        drain("entry_match");
        chk("entering_after_complete", entering, 0);

        push_playback(2, 8'b0000_0110);
        do_play();
        drain("replay_2_1");
        exp_q.push_back(mk(0, 0, 2'b00, 0, 0, 1, 0, 0));
        do_check(2'd3);
        drain("entry_mismatch");
        chk("length_after_mismatch", length, 2);
        chk("entering_after_mismatch", entering, 0);

        // Append and play together: the append wins and no playback may start.
        do_clear();
        chk("length_after_clear", length, 0);
        do_append(2'd3);
        random_bits = 2'd2;
        append = 1'b1;
        play = 1'b1;
        tick(1);
        append = 1'b0;
        play = 1'b0;
        tick(4);
        chk("append_beats_play_len", length, 2);
        chk("append_beats_play_busy", busy, 0);

        do_clear();
        do_append(2'd0);
        do_append(2'd1);
        do_append(2'd2);
        do_append(2'd3);
        do_append(2'd0);
        chk("length_full", length, 4);
        chk("full_flag", full, 1);
        push_playback(4, 8'b11_10_01_00);
        do_play();
        drain("playback_full");
        exp_q.push_back(mk(0, 0, 2'b00, 0, 1, 0, 0, 1));
        do_check(2'd0);
        exp_q.push_back(mk(0, 0, 2'b00, 0, 1, 0, 0, 1));
        do_check(2'd1);
        exp_q.push_back(mk(0, 0, 2'b00, 0, 1, 0, 0, 1));
        do_check(2'd2);
        exp_q.push_back(mk(0, 0, 2'b00, 0, 1, 0, 1, 0));
        do_check(2'd3);
        drain("entry_full");

        do_clear();
        exp_q.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 0));
        do_play();
        drain("play_empty");
        chk("play_empty_enable", enable, 0);
        chk("play_empty_entering", entering, 0);

        // Clear wins over a simultaneous correct entry: no result pulse.
        do_append(2'd1);
        push_playback(1, 8'h01);
        do_play();
        drain("playback_single");
        check_color = 2'd1;
        check_valid = 1'b1;
        clear = 1'b1;
        tick(1);
        check_valid = 1'b0;
        clear = 1'b0;
        tick(1);
        chk("clear_in_entry_len", length, 0);
        chk("clear_in_entry_entering", entering, 0);

        do_append(2'd2);
        do_append(2'd1);
        repeat (OnT) exp_q.push_back(mk(1, 1, 2'd2, 0, 0, 0, 0, 0));
        repeat (OffT) exp_q.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(1, 1, 2'd1, 0, 0, 0, 0, 0));
        do_play();
        tick(OnT + OffT);
        reset = 1'b0;
        tick(1);
        chk("midplay_reset_enable", enable, 0);
        chk("midplay_reset_busy", busy, 0);
        chk("midplay_reset_length", length, 0);
        chk("midplay_reset_full", full, 0);
        reset = 1'b1;
        tick(2);
        drain("midplay_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
